// File: rtl/pipa_moding_sched_if.sv
// pipa_moding_sched_if: PIPA spoofer control, config and pulse bundle.
// PIPA_NETCOUNT_EN adds the net-count clear and counter lines.
interface pipa_moding_sched_if;
  logic        PIPDAT;
  logic        PIPASW;
  logic        CFG_WR;
  logic [1:0]  CFG_AXIS;
  logic [2:0]  CFG_PLUS;
  logic [2:0]  CFG_MINUS;
  logic        CFG_BUSY;
  logic        PIPAXp;
  logic        PIPAXm;
  logic        PIPAYp;
  logic        PIPAYm;
  logic        PIPAZp;
  logic        PIPAZm;
`ifdef PIPA_NETCOUNT_EN
  logic        NET_CLR;
  logic [15:0] NETX;
  logic [15:0] NETY;
  logic [15:0] NETZ;

  modport master (
    output PIPDAT, PIPASW, CFG_WR,
    output CFG_AXIS, CFG_PLUS, CFG_MINUS,
    output NET_CLR,
    input  CFG_BUSY,
    input  PIPAXp, PIPAXm, PIPAYp,
    input  PIPAYm, PIPAZp, PIPAZm,
    input  NETX, NETY, NETZ
  );

  modport slave (
    input  PIPDAT, PIPASW, CFG_WR,
    input  CFG_AXIS, CFG_PLUS, CFG_MINUS,
    input  NET_CLR,
    output CFG_BUSY,
    output PIPAXp, PIPAXm, PIPAYp,
    output PIPAYm, PIPAZp, PIPAZm,
    output NETX, NETY, NETZ
  );
`else
  modport master (
    output PIPDAT, PIPASW, CFG_WR,
    output CFG_AXIS, CFG_PLUS, CFG_MINUS,
    input  CFG_BUSY,
    input  PIPAXp, PIPAXm, PIPAYp,
    input  PIPAYm, PIPAZp, PIPAZm
  );

  modport slave (
    input  PIPDAT, PIPASW, CFG_WR,
    input  CFG_AXIS, CFG_PLUS, CFG_MINUS,
    output CFG_BUSY,
    output PIPAXp, PIPAXm, PIPAYp,
    output PIPAYm, PIPAZp, PIPAZm
  );
`endif
endinterface

// File: rtl/pipa_moding_sched.sv
// pipa_moding_sched: per-axis plus/minus PIPA window spoofer.
// Optional macro PIPA_NETCOUNT_EN adds per-axis net pulse counters.
module pipa_moding_sched #(
  parameter int RESET_PLUS  = 3,
  parameter int RESET_MINUS = 3
) (
  input logic SIM_CLK,
  input logic SIM_RST,
  pipa_moding_sched_if.slave bus
);
  localparam logic [2:0] RP = 3'(RESET_PLUS);
  localparam logic [2:0] RM = 3'(RESET_MINUS);

  logic sw_q;
  logic sw_edge;
  logic busy;

  assign sw_edge = bus.PIPASW & ~sw_q;

  for (genvar i = 0; i < 3; i++) begin : ax
    localparam logic [1:0] AX = 2'(i);

    logic [2:0] p_act;
    logic [2:0] m_act;
    logic [2:0] p_pnd;
    logic [2:0] m_pnd;
    logic       pnd;
    logic       pnd_nxt;
    logic [3:0] phase;
    logic [3:0] tot;
    logic       idle;
    logic       wrap;
    logic       apply;
    logic       hit;
    logic       lo;
    logic       plus;
    logic       minus;

    assign tot   = {1'b0, p_act} + {1'b0, m_act};
    assign idle  = (tot == 4'd0);
    assign wrap  = sw_edge & ~idle
                 & (phase == tot - 4'd1);
    assign apply = pnd & (idle | wrap);
    assign hit   = bus.CFG_WR
                 & ((bus.CFG_AXIS == AX)
                 | (bus.CFG_AXIS == 2'd3));
    // a same-cycle write wins over the clear
    assign pnd_nxt = hit | (pnd & ~apply);
    assign lo    = phase < {1'b0, p_act};
    assign plus  = bus.PIPDAT & ~idle & lo;
    assign minus = bus.PIPDAT & ~idle & ~lo;

    // window phase plus active/pending config
    always_ff @(posedge SIM_CLK) begin
      if (!SIM_RST) begin
        phase <= 4'd0;
        p_act <= RP;
        m_act <= RM;
        p_pnd <= 3'd0;
        m_pnd <= 3'd0;
        pnd   <= 1'b0;
      end else begin
        if (idle) begin
          phase <= 4'd0;
        end else if (sw_edge) begin
          phase <= wrap ? 4'd0 : phase + 4'd1;
        end
        if (apply) begin
          p_act <= p_pnd;
          m_act <= m_pnd;
        end
        pnd <= pnd_nxt;
        if (hit) begin
          p_pnd <= bus.CFG_PLUS;
          m_pnd <= bus.CFG_MINUS;
        end
      end
    end

`ifdef PIPA_NETCOUNT_EN
    logic [15:0] net;

    // net count uses the pre-advance phase
    always_ff @(posedge SIM_CLK) begin
      if (!SIM_RST) begin
        net <= 16'd0;
      end else if (bus.NET_CLR) begin
        net <= 16'd0;
      end else if (sw_edge & bus.PIPDAT & ~idle) begin
        net <= lo ? net + 16'd1 : net - 16'd1;
      end
    end
`endif
  end

  // sample-switch history and busy flag
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      sw_q <= 1'b0;
      busy <= 1'b0;
    end else begin
      sw_q <= bus.PIPASW;
      busy <= ax[0].pnd_nxt
            | ax[1].pnd_nxt
            | ax[2].pnd_nxt;
    end
  end

  assign bus.CFG_BUSY = busy;
  assign bus.PIPAXp   = ax[0].plus;
  assign bus.PIPAXm   = ax[0].minus;
  assign bus.PIPAYp   = ax[1].plus;
  assign bus.PIPAYm   = ax[1].minus;
  assign bus.PIPAZp   = ax[2].plus;
  assign bus.PIPAZm   = ax[2].minus;

`ifdef PIPA_NETCOUNT_EN
  assign bus.NETX = ax[0].net;
  assign bus.NETY = ax[1].net;
  assign bus.NETZ = ax[2].net;
`endif
endmodule

// File: tb/tb_pipa_moding_sched.sv
// tb_pipa_moding_sched: table, directed and random checks
// of pipa_moding_sched against a window-position model.
module tb_pipa_moding_sched;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipa_moding_sched_if bus();

  pipa_moding_sched dut (
    .SIM_CLK(clk),
    .SIM_RST(rst),
    .bus    (bus)
  );

  localparam logic [5:0] ALLP = 6'b101010;
  localparam logic [5:0] ALLM = 6'b010101;

  int total = 0;
  int bad   = 0;

  int mp[3];
  int mm[3];
  int pp[3];
  int pm[3];
  int pos[3];
  int mnet[3];
  bit pf[3];
  bit mbusy;
  bit msw;

  logic [5:0] last_vec;

  typedef struct {
    logic       d;
    logic       s;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm,
                     input logic [15:0] a,
                     input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h",
               nm, a, e);
    end
  endtask

  function automatic logic [5:0] m_vec(input logic d);
    logic [5:0] v;
    v = '0;
    for (int a = 0; a < 3; a++) begin
      if (d && (mp[a] + mm[a] > 0)) begin
        if (pos[a] < mp[a]) v[5-2*a] = 1'b1;
        else v[4-2*a] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic void m_step(
    input logic r, input logic d, input logic s,
    input logic w, input logic [1:0] ax,
    input int cp, input int cm, input logic nc);
    bit sedge;
    int n;
    if (!r) begin
      for (int a = 0; a < 3; a++) begin
        mp[a] = 3; mm[a] = 3; pos[a] = 0;
        pf[a] = 0; mnet[a] = 0;
        pp[a] = 0; pm[a] = 0;
      end
      mbusy = 0;
      msw = 0;
      return;
    end
    sedge = s && !msw;
    msw = s;
    for (int a = 0; a < 3; a++) begin
      n = mp[a] + mm[a];
      if (n == 0) begin
        if (pf[a]) begin
          mp[a] = pp[a]; mm[a] = pm[a]; pf[a] = 0;
        end
        pos[a] = 0;
      end else if (sedge) begin
        if (d) mnet[a] += (pos[a] < mp[a]) ? 1 : -1;
        pos[a] = (pos[a] + 1) % n;
        if (pos[a] == 0 && pf[a]) begin
          mp[a] = pp[a]; mm[a] = pm[a]; pf[a] = 0;
        end
      end
      if (w && (ax == 2'd3 || int'(ax) == a)) begin
        pp[a] = cp; pm[a] = cm; pf[a] = 1;
      end
      if (nc) mnet[a] = 0;
    end
    mbusy = pf[0] | pf[1] | pf[2];
  endfunction

  task automatic step(input logic r, input logic d,
                      input logic s, input logic w,
                      input logic [1:0] ax,
                      input logic [2:0] cp,
                      input logic [2:0] cm,
                      input logic nc);
    @(negedge clk);
    rst = r;
    bus.PIPDAT = d;
    bus.PIPASW = s;
    bus.CFG_WR = w;
    bus.CFG_AXIS = ax;
    bus.CFG_PLUS = cp;
    bus.CFG_MINUS = cm;
`ifdef PIPA_NETCOUNT_EN
    bus.NET_CLR = nc;
`endif
    #1;
    last_vec = {bus.PIPAXp, bus.PIPAXm, bus.PIPAYp,
                bus.PIPAYm, bus.PIPAZp, bus.PIPAZm};
    chk("pulses", 16'(last_vec), 16'(m_vec(d)));
    chk("busy", 16'(bus.CFG_BUSY), 16'(mbusy));
`ifdef PIPA_NETCOUNT_EN
    chk("netx", bus.NETX, 16'(mnet[0]));
    chk("nety", bus.NETY, 16'(mnet[1]));
    chk("netz", bus.NETZ, 16'(mnet[2]));
`endif
    m_step(r, d, s, w, ax, int'(cp), int'(cm), nc);
  endtask

  task automatic idle1(input logic d);
    step(1'b1, d, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic edge1(input logic d);
    step(1'b1, d, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
    idle1(1'b0);
  endtask

  task automatic wr(input logic [1:0] ax,
                    input logic [2:0] cp,
                    input logic [2:0] cm);
    step(1'b1, 1'b0, 1'b0, 1'b1, ax, cp, cm, 1'b0);
  endtask

  task automatic rst1();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    for (int e = 0; e < 12; e++) begin
      tbl[2*e]   = '{1'b1, 1'b1,
                     ((e % 6) < 3) ? ALLP : ALLM};
      tbl[2*e+1] = '{1'b0, 1'b0, 6'b0};
    end

    rst = 1'b0;
    bus.PIPDAT = 1'b0;
    bus.PIPASW = 1'b0;
    bus.CFG_WR = 1'b0;
    bus.CFG_AXIS = 2'd0;
    bus.CFG_PLUS = 3'd0;
    bus.CFG_MINUS = 3'd0;
`ifdef PIPA_NETCOUNT_EN
    bus.NET_CLR = 1'b0;
`endif
    m_step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0);
    @(posedge clk);

    // reset state
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
    chk("rst_pulse", 16'(last_vec), 16'(ALLP));
    chk("rst_busy", 16'(bus.CFG_BUSY), 16'd0);

    // default 3/3 windows over 12 edges
    for (int i = 0; i < 24; i++) begin
      step(1'b1, tbl[i].d, tbl[i].s, 1'b0,
           2'd0, 3'd0, 3'd0, 1'b0);
      chk("tbl", 16'(last_vec), 16'(tbl[i].exp));
    end

    // X reconfig at phase 2
    edge1(1'b0);
    edge1(1'b0);
    wr(2'd0, 3'd1, 3'd2);
    idle1(1'b0);
    chk("busy_set", 16'(bus.CFG_BUSY), 16'd1);
    for (int i = 0; i < 4; i++) edge1(1'b0);
    idle1(1'b1);
    chk("busy_clr", 16'(bus.CFG_BUSY), 16'd0);
    chk("x_ph0", 16'(last_vec), 16'(6'b101010));
    edge1(1'b0);
    idle1(1'b1);
    chk("x_ph1", 16'(last_vec), 16'(6'b011010));
    edge1(1'b0);
    edge1(1'b0);

    // write coincident with X wrap
    wr(2'd0, 3'd2, 3'd2);
    edge1(1'b0);
    edge1(1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 3'd3, 3'd1, 1'b0);
    idle1(1'b0);
    chk("busy_keep", 16'(bus.CFG_BUSY), 16'd1);
    idle1(1'b1);
    chk("x_old_p", 16'(last_vec[5:4]), 16'd2);
    edge1(1'b0);
    edge1(1'b0);
    idle1(1'b1);
    chk("x_old_m", 16'(last_vec[5:4]), 16'd1);
    edge1(1'b0);
    edge1(1'b0);
    idle1(1'b0);
    chk("busy_clr2", 16'(bus.CFG_BUSY), 16'd0);

    // idle axes then plus-only
    wr(2'd3, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) edge1(1'b1);
    idle1(1'b1);
    chk("idle_out", 16'(last_vec), 16'd0);
    chk("idle_busy", 16'(bus.CFG_BUSY), 16'd0);
    wr(2'd3, 3'd2, 3'd0);
    idle1(1'b1);
    chk("pend_idle", 16'(last_vec), 16'd0);
    chk("pend_busy", 16'(bus.CFG_BUSY), 16'd1);
    idle1(1'b1);
    chk("plus_only", 16'(last_vec), 16'(ALLP));
    for (int i = 0; i < 10; i++) begin
      logic d;
      logic s;
      d = 1'($urandom);
      s = 1'($urandom);
      step(1'b1, d, s, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
      chk("plus_follow", 16'(last_vec),
          16'(d ? ALLP : 6'b0));
    end

    // reset mid-minus-window with pending config
    rst1();
    for (int i = 0; i < 4; i++) edge1(1'b0);
    wr(2'd1, 3'd1, 3'd1);
    rst1();
    idle1(1'b1);
    chk("rst2_busy", 16'(bus.CFG_BUSY), 16'd0);
    chk("rst2_ph0", 16'(last_vec), 16'(ALLP));
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b0);
    chk("rst2_edge", 16'(last_vec), 16'(ALLP));
    idle1(1'b0);
    edge1(1'b0);
    edge1(1'b0);
    idle1(1'b1);
    chk("rst2_33", 16'(last_vec), 16'(ALLM));

`ifdef PIPA_NETCOUNT_EN
    rst1();
    for (int i = 0; i < 6; i++) edge1(1'b1);
    idle1(1'b0);
    chk("net6", bus.NETX, 16'd0);
    for (int i = 0; i < 3; i++) edge1(1'b1);
    idle1(1'b0);
    chk("net9", bus.NETX, 16'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b1);
    idle1(1'b0);
    chk("net_clr", bus.NETX, 16'd0);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic w;
      logic nc;
      r  = ($urandom % 60) != 0;
      w  = ($urandom % 6) == 0;
      nc = ($urandom % 30) == 0;
`ifndef PIPA_NETCOUNT_EN
      nc = 1'b0;
`endif
      step(r, 1'($urandom), 1'($urandom), w,
           2'($urandom), 3'($urandom),
           3'($urandom), nc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipa_moding_sched.md
PIPA_MODING_SCHED -- requirements
Module: pipa_moding_sched

Interface
REQ-001 Parameter RESET_PLUS, default 3, plus-window length in PIPASW periods, loaded at reset for every axis.
REQ-002 Parameter RESET_MINUS, default 3, minus-window length in PIPASW periods, loaded at reset for every axis.
REQ-003 SIM_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 SIM_RST  in  1  synchronous, active-low reset.
REQ-005 PIPDAT  in  1  AGC PIPA data strobe, SIM_CLK domain.
REQ-006 PIPASW  in  1  AGC PIPA sample switch, SIM_CLK domain.
REQ-007 CFG_WR  in  1  one-cycle config write strobe.
REQ-008 CFG_AXIS  in  2  config target: 0=X, 1=Y, 2=Z, 3=all three.
REQ-009 CFG_PLUS  in  3  requested plus-window length, 0..7.
REQ-010 CFG_MINUS  in  3  requested minus-window length, 0..7.
REQ-011 CFG_BUSY  out  1  high while any axis holds a pending config.
REQ-012 PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  out  1 each  spoofed PIPA pulse lines to the AGC.

Function
REQ-013 Each axis shall hold an active config (P, M, 3 bits each), a pending config plus pending flag, and a 4-bit phase counter.
REQ-014 PIPASW shall be registered each cycle; a sample edge is PIPASW=1 with the registered copy 0.
REQ-015 On a sample edge, an axis with P+M>0 shall advance phase by 1; if phase equals P+M-1, phase shall return to 0 instead.
REQ-016 A pending config shall become active only on a sample edge at which phase wraps to 0, and the pending flag shall clear in the same cycle.
REQ-017 If active P+M=0 (axis idle), a pending config shall become active on the next SIM_CLK edge with phase forced to 0, independent of PIPASW.
REQ-018 PIPAnp shall equal PIPDAT AND (P+M>0) AND (phase<P); PIPAnm shall equal PIPDAT AND (P+M>0) AND (phase>=P); both are combinational from registered state and PIPDAT.
REQ-019 PIPAnp and PIPAnm shall never be high together; P=0 gives minus-only, M=0 gives plus-only, P=M=0 gives both low.
REQ-020 A CFG_WR shall overwrite the pending config of each targeted axis and set its pending flag; writes are always accepted, with no back-pressure.
REQ-021 If CFG_WR and an apply event for the same axis occur in one cycle, the old pending config shall apply and the new write shall remain pending.
REQ-022 CFG_BUSY shall be registered: it is the OR of the three pending flags after each clock edge.

Reset
REQ-023 While SIM_RST=0 at a clock edge, the following shall hold: all phases=0; active P=RESET_PLUS and M=RESET_MINUS on all axes; pending flags=0; CFG_BUSY=0; registered PIPASW=0.
REQ-024 Reset shall take priority over CFG_WR and sample edges in the same cycle; a reset mid-window shall discard any pending config.
REQ-025 After reset with defaults, PIPAnp shall follow PIPDAT during phases 0..2 and PIPAnm during phases 3..5.

Configuration
REQ-026 With macro PIPA_NETCOUNT_EN defined, the block shall add an input NET_CLR (1 bit) and outputs NETX, NETY, NETZ (16-bit two's complement each), all reset to 0.
REQ-027 With PIPA_NETCOUNT_EN, on a sample edge with PIPDAT=1, each active axis counter shall increment if phase<P and decrement otherwise, wrapping modulo 2^16, using pre-advance phase.
REQ-028 With PIPA_NETCOUNT_EN, NET_CLR=1 shall zero all three counters and take priority over a simultaneous count.
REQ-029 Without PIPA_NETCOUNT_EN, the NET_CLR, NETX, NETY and NETZ ports and the counter logic shall be absent, and all other behaviour shall be unchanged.

Verification
REQ-030 Reset, then 12 sample edges with PIPDAT=1 on each -> per axis, plus pulses at edges 1-3 and 7-9, minus pulses at edges 4-6 and 10-12.
REQ-031 At phase 2, write CFG_AXIS=0, P=1, M=2 -> CFG_BUSY=1 until the X wrap edge; X then runs 1 plus/2 minus while Y and Z keep 3/3.
REQ-032 Write P=0, M=0 to all axes, then P=2, M=0 -> all outputs low until the wrap; the second write applies 1 clock after idle, and PIPAnp then follows PIPDAT continuously.
REQ-033 Issue CFG_WR in the same cycle as an X wrap edge with a pending config -> the old config applies and CFG_BUSY stays 1 until the next wrap.
REQ-034 With PIPA_NETCOUNT_EN, defaults, 6 edges with PIPDAT=1 -> NETX=0; after 3 more edges NETX=3; NET_CLR coincident with an edge -> NETX=0.
REQ-035 Assert SIM_RST=0 for 1 cycle mid-minus-window with a config pending -> phase=0, CFG_BUSY=0, config reverts to 3/3, and the next edge produces a plus pulse.
